// File: rtl/mac_accum_4_bit_pkg.sv
// Shared definitions for the 4-bit multiply-accumulate block:
// operand width and controller state encodings.
package mac_accum_4_bit_pkg;

    localparam int OP_W = 4;
    localparam int PROD_W = 2 * OP_W;

    // 2'b11 is unused; the controller recovers from it to ACCUM.
    typedef enum logic [1:0] {
        ACCUM = 2'b00,
        DRAIN = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/mac_accum_4_bit_if.sv
// Operand-in / result-out handshake bundle for mac_accum_4_bit.
// The master drives operands, clear and result acceptance.
interface mac_accum_4_bit_if
    import mac_accum_4_bit_pkg::*;
#(
    parameter int ACC_W = 10
) ();

    logic              clr;
    logic [OP_W-1:0]   x;
    logic [OP_W-1:0]   y;
    logic              in_valid;
    logic              in_ready;
    logic [ACC_W-1:0]  acc_out;
    logic              ovf;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output clr, x, y, in_valid, out_ready,
        input  in_ready, acc_out, ovf, out_valid
    );

    modport slave (
        input  clr, x, y, in_valid, out_ready,
        output in_ready, acc_out, ovf, out_valid
    );

endinterface

// File: rtl/mul_4_bit_op.sv
// Combinational 4x4 unsigned multiplier producing a full 8-bit product.
module mul_4_bit_op
    import mac_accum_4_bit_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] p
);

    assign p = PROD_W'(a) * PROD_W'(b);

endmodule

// File: rtl/mac_accum_4_bit.sv
// Sequential MAC: registers one product per accepted pair and sums
// N_TERMS products into a result presented on a valid/ready output.
module mac_accum_4_bit
    import mac_accum_4_bit_pkg::*;
#(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    mac_accum_4_bit_if.slave  bus
);

    localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TERMS - 1);

    state_t              st, st_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [ACC_W-1:0]    acc;
    logic                ovf_q;
    logic [PROD_W-1:0]   p_reg;
    logic                p_vld;
    logic [PROD_W-1:0]   prod;
    logic [ACC_W:0]      sum;
    logic                accept;
    logic                last;

    mul_4_bit_op u_mul (
        .a (bus.x),
        .b (bus.y),
        .p (prod)
    );

    // clr blocks acceptance so a pair offered during an abort is not lost silently
    assign bus.in_ready  = (st == ACCUM) && !bus.clr;
    assign bus.out_valid = (st == DONE);
    assign bus.acc_out   = acc;
    assign bus.ovf       = ovf_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign last   = (cnt == CNT_LAST);
    assign sum    = {1'b0, acc} + (ACC_W + 1)'(p_reg);

    always_comb begin
        st_nxt = st;
        case (st)
            ACCUM:   if (accept && last) st_nxt = DRAIN;
            DRAIN:   st_nxt = DONE;
            DONE:    if (bus.out_ready) st_nxt = ACCUM;
            default: st_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st    <= ACCUM;
            cnt   <= '0;
            acc   <= '0;
            ovf_q <= 1'b0;
            p_reg <= '0;
            p_vld <= 1'b0;
        end else if (bus.clr) begin
            st    <= ACCUM;
            cnt   <= '0;
            acc   <= '0;
            ovf_q <= 1'b0;
            p_vld <= 1'b0;
        end else begin
            st    <= st_nxt;
            p_vld <= accept;
            if (accept) begin
                p_reg <= prod;
                cnt   <= last ? '0 : cnt + 1'b1;
            end
            // p_vld is never set while in DONE, so the two branches cannot collide
            if (st == DONE && bus.out_ready) begin
                acc   <= '0;
                ovf_q <= 1'b0;
            end else if (p_vld) begin
                acc <= sum[ACC_W-1:0];
                if (sum[ACC_W]) ovf_q <= 1'b1;
            end
        end
    end

endmodule
